counter_checker: RTL and testbench
==================================

# counter_checker

Synthesizable self-checking monitor for the free-running `counter` block. It sits on the consumer side of the counter's `value` bus and samples that bus every enabled clock, tracking the expected next value. It flags any step that is not exactly +1 modulo 2^WIDTH, and keeps a saturating error tally. It is the hardware counterpart of the bench scoreboard, so FPGA builds can check the counter without a simulator.

## Interface
- `WIDTH`, default 8: width of the monitored `value` bus.
- `LOCK_CNT`, default 2: consecutive correct increments required before checking is armed (range 1..15).
- `CNT_W`, default 8: width of `err_count`.
- `clk`  in  1  rising-edge clock, shared with the monitored counter.
- `reset`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `value`  in  WIDTH  counter output under check.
- `en`  in  1  sample enable; when 0, all state holds and no comparison is made.
- `locked`  out  1  checker is armed (state LOCKED).
- `err`  out  1  one-cycle pulse on a detected mismatch while locked.
- `err_count`  out  CNT_W  number of mismatches since reset; saturates at all-ones.
- `expected`  out  WIDTH  value the checker expects at the next enabled sample.

## Operation
- States: SYNC and LOCKED. The reset state is SYNC.
- Reset values: `locked`=0, `err`=0, `err_count`=0, `expected`=0, internal match counter `mcnt`=0.
- SYNC, `en`=1:
  - If `value`==`expected`, then `mcnt`++. If `mcnt` reaches LOCK_CNT, go to LOCKED and set `mcnt`=0.
  - If `value`!=`expected`, adopt the sample silently: `mcnt`=1. No `err`, no count.
  - In both cases `expected` <= `value`+1.
- LOCKED, `en`=1, `value`==`expected`: `expected` <= `expected`+1; stay in LOCKED.
- LOCKED, `en`=1, `value`!=`expected`:
  - `err`=1 for one cycle and `err_count`++ (saturating).
  - Go to SYNC with `expected` <= `value`+1 and `mcnt`=1. The faulty sample is adopted as the new sync point.
- Arithmetic is modulo 2^WIDTH. All-ones followed by 0 is a correct increment (wrap-around), not an error.
- `en`=0: no state, output or counter changes, except that `err` returns to 0.
- `reset`=1 overrides `en` and any mismatch in the same cycle. A mid-run reset returns the block to its reset values, including clearing `err_count`.
- `err_count` at all-ones: further mismatches still pulse `err`, but the count holds.

## Timing
- All outputs are registered and update on the rising `clk` edge that samples `value`/`en`.
- Mismatch latency: a bad `value` sampled at edge N drives `err`=1 from edge N to edge N+1, and `err_count` is incremented at edge N.
- Lock latency: after reset, with a correct counter and `en` held at 1, `locked` rises at the (LOCK_CNT+1)-th enabled edge (first sample adopts, then LOCK_CNT matches).
- Back-to-back errors are impossible: a mismatch always forces SYNC, and SYNC never flags.
- The monitored counter's synchronous reset and this block's `reset` are the same net. No cross-reset handshake is needed.

## Structure
- Package `counter_checker_pkg`:
  - state type `chk_state_t` {SYNC, LOCKED}
  - default constants `CHK_WIDTH`=8, `CHK_LOCK_CNT`=2, `CHK_CNT_W`=8
- One sub-module: `sat_counter`, a parameterized CNT_W-bit up-counter with synchronous reset, increment enable and hold at all-ones. It implements `err_count`.
- Comparator, next-expected adder and state register stay in `counter_checker`.
- Target size: about 150 RTL lines plus about 40 for `sat_counter`.

## Test plan
- Reset, then `value`=0,1,2,3 with `en`=1 → `locked`=1 after the third edge, `err` stays 0, `expected`=4.
- Locked at `expected`=0x10, drive `value`=0x12 → `err` pulses exactly one cycle, `err_count`=1, `locked`=0, `expected`=0x13. Then `value`=0x13,0x14 → `locked`=1 again, no new error.
- Locked at `value`=0xFE,0xFF,0x00,0x01 → no error; `expected` wraps to 0x00 and then reaches 0x02.
- Locked, drive `en`=0 for 5 cycles while `value` changes arbitrarily, then resume at `expected` → no error and `expected` unchanged across the gap.
- 260 forced mismatches (alternate good/bad to relock, or drive constant 0x00) → `err` pulses on each locked mismatch and `err_count` saturates at 0xFF.
- Mismatch and `reset`=1 in the same cycle → `err`=0, `err_count`=0, `locked`=0, `expected`=0.

Source files
------------

// File: rtl/counter_checker_pkg.sv
// Shared types and default parameters for the counter_checker monitor.
package counter_checker_pkg;

    typedef enum logic {
        SYNC   = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    localparam int CHK_WIDTH    = 8;
    localparam int CHK_LOCK_CNT = 2;
    localparam int CHK_CNT_W    = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous reset that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/counter_checker.sv
// Monitors a free-running counter bus, flags any step that is not +1 (mod 2^WIDTH)
// once enough consecutive good steps have armed the checker.
module counter_checker
    import counter_checker_pkg::*;
#(
    parameter int WIDTH    = CHK_WIDTH,
    parameter int LOCK_CNT = CHK_LOCK_CNT,
    parameter int CNT_W    = CHK_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    input  logic             en,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH-1:0] expected
);

    localparam int MCNT_W = 4;
    localparam logic [MCNT_W-1:0] LOCK_TARGET = MCNT_W'(LOCK_CNT);
    localparam logic [MCNT_W-1:0] MCNT_ONE    = MCNT_W'(1);
    localparam logic [WIDTH-1:0]  VAL_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    chk_state_t        state;
    chk_state_t        state_next;
    logic [MCNT_W-1:0] mcnt;
    logic [MCNT_W-1:0] mcnt_next;
    logic [WIDTH-1:0]  expected_next;
    logic              err_next;
    logic              match;
    logic [WIDTH-1:0]  value_inc;
    logic [WIDTH-1:0]  expected_inc;

    assign match        = (value == expected);
    assign value_inc    = value + VAL_ONE;
    assign expected_inc = expected + VAL_ONE;
    assign locked       = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SYNC;
            mcnt     <= '0;
            expected <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            mcnt     <= mcnt_next;
            expected <= expected_next;
            err      <= err_next;
        end
    end

    // mcnt counts samples in the current good run, including the adopted one,
    // so arming needs LOCK_CNT genuine increments after the adoption point.
    always_comb begin
        state_next    = state;
        mcnt_next     = mcnt;
        expected_next = expected;
        err_next      = 1'b0;

        if (en) begin
            case (state)
                SYNC: begin
                    expected_next = value_inc;
                    if (match) begin
                        if (mcnt == LOCK_TARGET) begin
                            state_next = LOCKED;
                            mcnt_next  = '0;
                        end else begin
                            mcnt_next = mcnt + MCNT_ONE;
                        end
                    end else begin
                        mcnt_next = MCNT_ONE;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        expected_next = expected_inc;
                    end else begin
                        err_next      = 1'b1;
                        state_next    = SYNC;
                        expected_next = value_inc;
                        mcnt_next     = MCNT_ONE;
                    end
                end
                default: begin
                    state_next = SYNC;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (err_next),
        .count(err_count)
    );

endmodule

// File: tb/tb_counter_checker.sv
// Directed self-checking bench for counter_checker with hand-computed expectations.
module tb_counter_checker;

    logic       clk;
    logic       reset;
    logic [7:0] value;
    logic       en;
    logic       locked;
    logic       err;
    logic [7:0] err_count;
    logic [7:0] expected;

    int vectors;
    int miscompares;

    counter_checker #(
        .WIDTH   (8),
        .LOCK_CNT(2),
        .CNT_W   (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .en       (en),
        .locked   (locked),
        .err      (err),
        .err_count(err_count),
        .expected (expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the edge; outputs are then sampled well before the next one.
    task automatic applyStimulus(input logic r, input logic e, input logic [7:0] v);
        reset = r;
        en    = e;
        value = v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic exp_locked, input logic exp_err,
                               input logic [7:0] exp_cnt, input logic [7:0] exp_expected);
        checkOne({tag, ".locked"},    32'(locked),    32'(exp_locked));
        checkOne({tag, ".err"},       32'(err),       32'(exp_err));
        checkOne({tag, ".err_count"}, 32'(err_count), 32'(exp_cnt));
        checkOne({tag, ".expected"},  32'(expected),  32'(exp_expected));
    endtask

    initial begin
        logic [7:0] e;
        logic [7:0] cnt;
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        en    = 1'b0;
        value = 8'h00;
        #1;

        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("reset", 1'b0, 1'b0, 8'h00, 8'h00);

        // Lock-up from reset: arms on the third enabled edge
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("lock0", 1'b0, 1'b0, 8'h00, 8'h01);
        applyStimulus(1'b0, 1'b1, 8'h01);
        checkOutput("lock1", 1'b0, 1'b0, 8'h00, 8'h02);
        applyStimulus(1'b0, 1'b1, 8'h02);
        checkOutput("lock2", 1'b1, 1'b0, 8'h00, 8'h03);
        applyStimulus(1'b0, 1'b1, 8'h03);
        checkOutput("lock3", 1'b1, 1'b0, 8'h00, 8'h04);

        for (int i = 4; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'(i));
        checkOutput("run_to_10", 1'b1, 1'b0, 8'h00, 8'h10);

        // Skip ahead while locked, then relock on 0x13, 0x14
        applyStimulus(1'b0, 1'b1, 8'h12);
        checkOutput("skip", 1'b0, 1'b1, 8'h01, 8'h13);
        applyStimulus(1'b0, 1'b1, 8'h13);
        checkOutput("relock_a", 1'b0, 1'b0, 8'h01, 8'h14);
        applyStimulus(1'b0, 1'b1, 8'h14);
        checkOutput("relock_b", 1'b1, 1'b0, 8'h01, 8'h15);

        for (int i = 8'h15; i < 8'hFE; i++) applyStimulus(1'b0, 1'b1, 8'(i));
        checkOutput("run_to_fe", 1'b1, 1'b0, 8'h01, 8'hFE);

        // Wrap-around is a legal increment
        applyStimulus(1'b0, 1'b1, 8'hFE);
        checkOutput("wrap_fe", 1'b1, 1'b0, 8'h01, 8'hFF);
        applyStimulus(1'b0, 1'b1, 8'hFF);
        checkOutput("wrap_ff", 1'b1, 1'b0, 8'h01, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("wrap_00", 1'b1, 1'b0, 8'h01, 8'h01);
        applyStimulus(1'b0, 1'b1, 8'h01);
        checkOutput("wrap_01", 1'b1, 1'b0, 8'h01, 8'h02);

        // Enable gap: arbitrary values are ignored
        applyStimulus(1'b0, 1'b0, 8'h55);
        checkOutput("gap0", 1'b1, 1'b0, 8'h01, 8'h02);
        applyStimulus(1'b0, 1'b0, 8'hAA);
        checkOutput("gap1", 1'b1, 1'b0, 8'h01, 8'h02);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("gap2", 1'b1, 1'b0, 8'h01, 8'h02);
        applyStimulus(1'b0, 1'b0, 8'h37);
        checkOutput("gap3", 1'b1, 1'b0, 8'h01, 8'h02);
        applyStimulus(1'b0, 1'b0, 8'hFF);
        checkOutput("gap4", 1'b1, 1'b0, 8'h01, 8'h02);
        applyStimulus(1'b0, 1'b1, 8'h02);
        checkOutput("resume", 1'b1, 1'b0, 8'h01, 8'h03);

        // err drops when en falls right after a mismatch
        applyStimulus(1'b0, 1'b1, 8'h77);
        checkOutput("err_then_idle_a", 1'b0, 1'b1, 8'h02, 8'h78);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("err_then_idle_b", 1'b0, 1'b0, 8'h02, 8'h78);

        // A mismatch while syncing is adopted silently
        applyStimulus(1'b0, 1'b1, 8'h90);
        checkOutput("sync_miss", 1'b0, 1'b0, 8'h02, 8'h91);

        // Repeated relock-then-fault cycles drive err_count into saturation
        e   = 8'h91;
        cnt = 8'h02;
        for (int i = 0; i < 260; i++) begin
            applyStimulus(1'b0, 1'b1, e);
            applyStimulus(1'b0, 1'b1, e + 8'd1);
            checkOne($sformatf("sat%0d.locked", i), 32'(locked), 32'd1);
            applyStimulus(1'b0, 1'b1, e + 8'd7);
            if (cnt != 8'hFF) cnt = cnt + 8'd1;
            checkOne($sformatf("sat%0d.err", i), 32'(err), 32'd1);
            checkOne($sformatf("sat%0d.err_count", i), 32'(err_count), 32'(cnt));
            e = e + 8'd8;
        end
        checkOutput("saturated", 1'b0, 1'b1, 8'hFF, e);

        // Reset wins over a simultaneous mismatch
        applyStimulus(1'b0, 1'b1, e);
        applyStimulus(1'b0, 1'b1, e + 8'd1);
        checkOutput("pre_reset", 1'b1, 1'b0, 8'hFF, e + 8'd2);
        applyStimulus(1'b1, 1'b1, e + 8'd9);
        checkOutput("reset_vs_miss", 1'b0, 1'b0, 8'h00, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h40);
        checkOutput("post_reset", 1'b0, 1'b0, 8'h00, 8'h41);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
